// File: rtl/postbox_lcd_top.sv
// POST-port display adapter: decodes testreq pulse groups, acks OUTPUT, receives bytes and
// writes each to an HD44780 LCD (4-bit data + RS) with a single E strobe.
module postbox_lcd_top #(
    parameter int BREAK_CYCLES = 144,
    parameter int SETUP_CYCLES = 2,
    parameter int E_CYCLES     = 6,
    parameter int HOLD_CYCLES  = 2
) (
    input  logic DIL_1_GCK,
    input  logic rst,
    input  logic DIL_2_GCK,
    output logic DIL_3,
    output logic DIL_27,
    output logic DIL_26,
    output logic DIL_25,
    output logic DIL_24,
    output logic DIL_23,
    output logic DIL_22
);

    localparam int LW = $clog2(BREAK_CYCLES + 1);
    localparam int TW = 8;

    typedef enum logic {IDLE, RXBYTE} pstate_t;
    typedef enum logic [1:0] {L_IDLE, L_SETUP, L_EHIGH, L_HOLD} lstate_t;

    logic          req_m_q, req_s_q, req_p_q;
    logic [LW-1:0] low_q;
    logic [3:0]    pcnt_q;
    pstate_t       pst_q;
    logic [2:0]    bcnt_q;
    logic [7:0]    shift_q, byte_q;
    logic          pending_q, inp_req_q, ack_q;
    lstate_t       lst_q;
    logic [TW-1:0] tmr_q;
    logic [3:0]    dat_q;
    logic          rs_q, e_q;

    logic req_rise, group_end, rx_bit;
    logic [7:0] shift_d;

    assign req_rise  = req_s_q & ~req_p_q;
    assign group_end = ~req_s_q && (low_q == LW'(BREAK_CYCLES - 1)) && (pcnt_q != 4'd0);
    assign rx_bit    = (pcnt_q == 4'd2);
    assign shift_d   = {shift_q[6:0], rx_bit};

    always_ff @(posedge DIL_1_GCK) begin
        if (rst) begin
            req_m_q   <= 1'b0;
            req_s_q   <= 1'b0;
            req_p_q   <= 1'b0;
            low_q     <= '0;
            pcnt_q    <= 4'd0;
            pst_q     <= IDLE;
            bcnt_q    <= 3'd0;
            shift_q   <= 8'd0;
            byte_q    <= 8'd0;
            pending_q <= 1'b0;
            inp_req_q <= 1'b0;
            ack_q     <= 1'b0;
            lst_q     <= L_IDLE;
            tmr_q     <= '0;
            dat_q     <= 4'd0;
            rs_q      <= 1'b0;
            e_q       <= 1'b0;
        end else begin
            req_m_q <= DIL_2_GCK;
            req_s_q <= req_m_q;
            req_p_q <= req_s_q;

            if (req_s_q) begin
                low_q <= '0;
            end else if (low_q != LW'(BREAK_CYCLES)) begin
                low_q <= low_q + 1'b1;
            end

            if (group_end) begin
                pcnt_q <= 4'd0;
            end else if (req_rise && pcnt_q != 4'd15) begin
                pcnt_q <= pcnt_q + 4'd1;
            end

            // LCD sequencer comes first so protocol updates to pending/inp_req win on the same clock
            case (lst_q)
                L_IDLE: begin
                    if (inp_req_q) begin
                        inp_req_q <= 1'b0;
                        if (pending_q) begin
                            pending_q <= 1'b0;
                            dat_q     <= byte_q[7:4];
                            rs_q      <= byte_q[3];
                            tmr_q     <= '0;
                            lst_q     <= L_SETUP;
                        end
                    end
                end
                L_SETUP: begin
                    tmr_q <= tmr_q + 1'b1;
                    if (tmr_q == TW'(SETUP_CYCLES - 1)) begin
                        e_q   <= 1'b1;
                        tmr_q <= '0;
                        lst_q <= L_EHIGH;
                    end
                end
                L_EHIGH: begin
                    tmr_q <= tmr_q + 1'b1;
                    if (tmr_q == TW'(E_CYCLES - 1)) begin
                        e_q   <= 1'b0;
                        tmr_q <= '0;
                        lst_q <= L_HOLD;
                    end
                end
                default: begin
                    tmr_q <= tmr_q + 1'b1;
                    if (tmr_q == TW'(HOLD_CYCLES - 1)) begin
                        tmr_q <= '0;
                        lst_q <= L_IDLE;
                    end
                end
            endcase

            if (req_rise) begin
                ack_q <= 1'b0;
            end

            if (group_end) begin
                ack_q <= (pcnt_q == 4'd3);
                case (pcnt_q)
                    4'd4: begin
                        pst_q     <= IDLE;
                        bcnt_q    <= 3'd0;
                        pending_q <= 1'b0;
                        inp_req_q <= 1'b0;
                    end
                    4'd3: begin
                        pst_q  <= RXBYTE;
                        bcnt_q <= 3'd0;
                    end
                    4'd14: inp_req_q <= 1'b1;
                    4'd1, 4'd2: begin
                        if (pst_q == RXBYTE) begin
                            shift_q <= shift_d;
                            bcnt_q  <= bcnt_q + 3'd1;
                            if (bcnt_q == 3'd7) begin
                                byte_q    <= shift_d;
                                pending_q <= 1'b1;
                                pst_q     <= IDLE;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign DIL_3  = ack_q;
    assign DIL_27 = dat_q[3];
    assign DIL_26 = dat_q[2];
    assign DIL_25 = dat_q[1];
    assign DIL_24 = dat_q[0];
    assign DIL_23 = rs_q;
    assign DIL_22 = e_q;

endmodule

// File: tb/tb_postbox_lcd_top.sv
// Directed bench for postbox_lcd_top: pulse-group stimulus, LCD writes scoreboarded by an E-strobe monitor.
module tb_postbox_lcd_top;

    logic clk, rst, req;
    logic ack, d3, d2, d1, d0, rs, e;
    logic [3:0] dat;

    int checks = 0;
    int failures = 0;
    int strobes = 0;
    int base;
    logic [4:0] exp_q[$];

    postbox_lcd_top dut (
        .DIL_1_GCK(clk),
        .rst      (rst),
        .DIL_2_GCK(req),
        .DIL_3    (ack),
        .DIL_27   (d3),
        .DIL_26   (d2),
        .DIL_25   (d1),
        .DIL_24   (d0),
        .DIL_23   (rs),
        .DIL_22   (e)
    );

    assign dat = {d3, d2, d1, d0};

    initial clk = 1'b0;
    always #42 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic clk_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    // n pulses of 6 clocks high / 6 low, then a ~25 us break
    task automatic pulses(input int n);
        for (int i = 0; i < n; i++) begin
            req = 1'b1; clk_n(6);
            req = 1'b0; clk_n(6);
        end
        clk_n(300);
    endtask

    task automatic send_bits(input logic [7:0] b, input int hi);
        for (int i = hi; i >= 0; i--) pulses(b[i] ? 2 : 1);
    endtask

    // E-strobe monitor: pops the scoreboard on each E rise, checks setup and E width
    logic [4:0] mon_prev;
    logic       e_prev = 1'b0;
    int         stable = 0;
    int         hi_cnt = 0;
    always @(posedge clk) begin
        logic [4:0] cur, expv;
        #1;
        cur = {rs, dat};
        if (rst) begin
            e_prev = 1'b0;
            hi_cnt = 0;
            stable = 0;
            mon_prev = cur;
        end else begin
            if (cur !== mon_prev) stable = 0;
            else stable++;
            mon_prev = cur;
            if (e && !e_prev) begin
                strobes++;
                hi_cnt = 1;
                if (exp_q.size() == 0) begin
                    check("unexpected_strobe", 32'd1, 32'd0);
                end else begin
                    expv = exp_q.pop_front();
                    check("lcd_data", 32'(dat), 32'(expv[3:0]));
                    check("lcd_rs", 32'(rs), 32'(expv[4]));
                    check("setup_ge_2", 32'(stable >= 2), 32'd1);
                end
            end else if (e) begin
                hi_cnt++;
            end else if (e_prev) begin
                check("e_width", 32'(hi_cnt), 32'd6);
            end
            e_prev = e;
        end
    end

    initial begin
        #(60000 * 84);
        $display("FAIL watchdog_timeout observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        req = 1'b0;
        clk_n(5);
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_e", 32'(e), 32'd0);
        check("rst_rs", 32'(rs), 32'd0);
        check("rst_data", 32'(dat), 32'd0);
        rst = 1'b0;
        clk_n(5);

        // SYNC from idle
        pulses(4);
        check("sync_ack", 32'(ack), 32'd0);
        check("sync_no_strobe", 32'(strobes), 32'd0);

        // SYNC then OUTPUT: ack set, then cleared on next rise
        pulses(4);
        pulses(3);
        check("output_ack_set", 32'(ack), 32'd1);
        req = 1'b1; clk_n(4);
        check("ack_cleared_on_rise", 32'(ack), 32'd0);
        clk_n(2);
        req = 1'b0; clk_n(6);
        req = 1'b1; clk_n(6);
        req = 1'b0; clk_n(6);
        clk_n(300);
        send_bits(8'hA8, 6);
        check("rx_no_strobe", 32'(strobes), 32'd0);

        // INPUT chaser with pending 0xA8 -> data A, RS 1
        exp_q.push_back({1'b1, 4'hA});
        base = strobes;
        pulses(14);
        clk_n(20);
        check("input_one_strobe", 32'(strobes - base), 32'd1);
        check("input_data_hold", 32'(dat), 32'hA);

        // INPUT with nothing pending
        base = strobes;
        pulses(14);
        clk_n(20);
        check("input_no_pending", 32'(strobes - base), 32'd0);

        // Saturated count (19 pulses -> 15) is ignored
        pulses(19);
        check("saturate_ack", 32'(ack), 32'd0);

        // Partial byte, SYNC, then a fresh byte 0x50
        pulses(3);
        for (int i = 0; i < 5; i++) pulses(1);
        pulses(4);
        pulses(3);
        send_bits(8'h50, 7);
        exp_q.push_back({1'b0, 4'h5});
        base = strobes;
        pulses(14);
        clk_n(20);
        check("restart_one_strobe", 32'(strobes - base), 32'd1);

        // Reset while E is high
        pulses(3);
        send_bits(8'hF8, 7);
        exp_q.push_back({1'b1, 4'hF});
        for (int i = 0; i < 14; i++) begin
            req = 1'b1; clk_n(6);
            req = 1'b0; clk_n(6);
        end
        for (int i = 0; i < 400 && !e; i++) clk_n(1);
        check("e_rise_seen", 32'(e), 32'd1);
        rst = 1'b1;
        clk_n(1);
        check("midrst_e", 32'(e), 32'd0);
        check("midrst_data", 32'(dat), 32'd0);
        rst = 1'b0;
        clk_n(20);

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/postbox_lcd_top.md
Name: postbox_lcd_top

Overview:
- Acorn POST-port display adapter, top level of the CPLD.
- Decodes pulse groups on the host's testreq line, answers on testack, and receives bytes from the host.
- Writes each received byte to an HD44780-style LCD in 4-bit mode, one E strobe per byte.
- Transmit path is not implemented; every data bit the adapter returns reads as 0.

Parameters:
- BREAK_CYCLES, 144: consecutive clocks with synchronised testreq low that end a pulse group (12 us at 12 MHz).
- SETUP_CYCLES, 2: clocks that LCD data/RS are stable before E rises.
- E_CYCLES, 6: E high width in clocks (500 ns).
- HOLD_CYCLES, 2: clocks data/RS are held after E falls.

Ports:
- DIL_1_GCK  in  1  12 MHz reference clock; all logic on its rising edge.
- rst  in  1  synchronous active-high reset.
- DIL_2_GCK  in  1  testreq from host; asynchronous, double-flop synchronised.
- DIL_3  out  1  testack to host.
- DIL_27, DIL_26, DIL_25, DIL_24  out  1 each  LCD data bits 3, 2, 1, 0.
- DIL_23  out  1  LCD RS.
- DIL_22  out  1  LCD E.

Behaviour:
- Reset:
  - testack, E, RS and LCD data all 0.
  - FSM goes to IDLE; pulse count, bit count and the pending flag are cleared.
- Pulse counting:
  - Each rising edge of synchronised testreq increments a 4-bit group counter, which saturates at 15.
  - The low-time counter resets on any high sample.
  - When the low-time counter reaches BREAK_CYCLES with a nonzero group count, the group ends: the count is decoded for exactly one clock, then cleared.
  - Minimum recognisable pulse high/low width is 2 clocks.
- testack:
  - Set on the clock a group is decoded as OUTPUT (count 3).
  - Cleared on the next testreq rising edge.
  - Every other decode drives 0, so transmitted data is always 0x00.
- Group decode (count -> action), applies in every state:
  - 4 = SYNC: FSM to IDLE; clear bit count and pending; no effect on an LCD strobe already in progress.
  - 3 = OUTPUT: ack = 1; FSM to RXBYTE with bit count 0.
  - 14 = INPUT chaser: if a byte is pending, start an LCD write and clear pending; otherwise no LCD activity.
- RXBYTE state:
  - Each group of 1 shifts in bit 0; each group of 2 shifts in bit 1; MSB first.
  - After the 8th bit, latch the byte, set pending, FSM to IDLE.
  - Counts other than 1, 2, 3, 4 or 14 are ignored in RXBYTE and in IDLE.
  - Entering OUTPUT mid-byte restarts the byte and discards partial bits.
- LCD write mapping: data[3:0] = byte[7:4]; RS = byte[3]; byte[2:0] ignored.
- LCD write sequence:
  - Data/RS are driven, then E rises after SETUP_CYCLES.
  - E stays high for E_CYCLES, then falls.
  - Data/RS are held HOLD_CYCLES after E falls, then remain at their last value.
  - Exactly one E rising edge per write.
- Overlap rules:
  - An INPUT arriving while a write is in progress waits until the write finishes.
  - A new byte may be received while a write is in progress.
- Reset mid-operation: applies immediately; E drops to 0 the same clock.

Test Plan:
- Reset, then four pulses (500 ns high / 500 ns low) + 25 us break -> FSM IDLE, testack 0, no E strobe.
- SYNC, then three pulses + break -> testack 1 when sampled at end of break; cleared on next testreq rise.
- OUTPUT, then byte 0xA8 as groups 2,1,2,1,2,1,1,1 (each followed by a break) -> zero E strobes, pending set.
- Then 14-pulse group + break, wait 1 us -> exactly one E strobe; data = 0xA, RS = 1; E high 6 clocks, setup ≥ 2 clocks.
- 14-pulse group with no pending byte -> zero E strobes.
- Five bits of a byte, then SYNC, then OUTPUT + byte 0x50 + INPUT -> one strobe with data 0x5, RS = 0; partial byte discarded.
